// File: rtl/dma_channel_scheduler_if.sv
// Bus-side bundle of the DMA channel scheduler.
// master: scheduler drives HRQ/DACK/GRANT_CH/XFER_START/XFER_ABORT;
// slave: CPU and timing block drive HLDA/XFER_DONE/TC/EOP_N.
interface dma_channel_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
);
  logic              HRQ;
  logic              HLDA;
  logic [NUM_CH-1:0] DACK;
  logic [CH_W-1:0]   GRANT_CH;
  logic              XFER_START;
  logic              XFER_ABORT;
  logic              XFER_DONE;
  logic              TC;
  logic              EOP_N;

  modport master (
    output HRQ,
    output DACK,
    output GRANT_CH,
    output XFER_START,
    output XFER_ABORT,
    input  HLDA,
    input  XFER_DONE,
    input  TC,
    input  EOP_N
  );

  modport slave (
    input  HRQ,
    input  DACK,
    input  GRANT_CH,
    input  XFER_START,
    input  XFER_ABORT,
    output HLDA,
    output XFER_DONE,
    output TC,
    output EOP_N
  );
endinterface

// File: rtl/dma_channel_scheduler.sv
// Request-side sequencer of the 4-channel DMA controller.
// Ports: CLK, RESET_N (async low); DREQ/MASK/ROTATE/MODE/CLR_TC in;
// TC_STATUS out; bus = HRQ/HLDA/DACK/GRANT_CH/XFER_* /TC/EOP_N.
module dma_channel_scheduler #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [NUM_CH-1:0]   DREQ,
  input  logic [NUM_CH-1:0]   MASK,
  input  logic                ROTATE,
  input  logic [2*NUM_CH-1:0] MODE,
  input  logic [NUM_CH-1:0]   CLR_TC,
  output logic [NUM_CH-1:0]   TC_STATUS,
  dma_channel_scheduler_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GRANT,
    S_XFER,
    S_REL
  } state_t;

  state_t state_q, state_d;

  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [NUM_CH-1:0] tcs_q, tcs_d;
  logic [NUM_CH-1:0] tc_set;
  logic [NUM_CH-1:0] ereq;
  logic              eop_q, eop_d;
  logic              abort_q, abort_d;

  logic [CH_W-1:0]   winner;
  logic [CH_W-1:0]   idx;
  logic              found;
  logic [1:0]        cur_mode;
  logic              is_block;
  logic              is_demand;
  logic              bus_act;

  assign ereq = DREQ & ~MASK & ~tcs_q;

  // Search order starts after the pointer when rotating;
  // index arithmetic wraps because NUM_CH is a power of two.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = ROTATE ? ptr_q + CH_W'(1) + CH_W'(i)
                   : CH_W'(i);
      if (!found && ereq[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Mode 11 falls through to single behaviour.
  assign cur_mode  = MODE[{grant_q, 1'b0} +: 2];
  assign is_block  = (cur_mode == 2'b10);
  assign is_demand = (cur_mode == 2'b00);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    tc_set  = '0;
    eop_d   = eop_q;
    abort_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|ereq) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.HLDA) begin
          if (|ereq) begin
            grant_d = winner;
            state_d = S_GRANT;
          end else begin
            state_d = S_REL;
          end
        end
      end
      S_GRANT: begin
        if (!bus.HLDA) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (!bus.HLDA) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
        end else if (bus.XFER_DONE) begin
          if (bus.TC || eop_q) begin
            tc_set[grant_q] = 1'b1;
            state_d = S_REL;
          end else begin
            unique case (1'b1)
              is_block:
                state_d = S_GRANT;
              is_demand && DREQ[grant_q]:
                state_d = S_GRANT;
              default:
                state_d = S_REL;
            endcase
          end
          // Just-serviced channel drops to lowest priority.
          if (state_d == S_REL && ROTATE)
            ptr_d = grant_q;
        end
      end
      S_REL: begin
        if (!bus.HLDA) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_q == S_GRANT || state_q == S_XFER)
        && !bus.EOP_N)
      eop_d = 1'b1;
    // EOP belongs to one transfer only; also drop it on abort.
    if (state_q == S_XFER && state_d != S_XFER)
      eop_d = 1'b0;
    if (state_d == S_IDLE)
      eop_d = 1'b0;
  end

  // Set beats clear on the same bit.
  assign tcs_d = (tcs_q & ~CLR_TC) | tc_set;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= CH_W'(NUM_CH - 1);
      tcs_q   <= '0;
      eop_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      tcs_q   <= tcs_d;
      eop_q   <= eop_d;
      abort_q <= abort_d;
    end
  end

  assign bus_act = (state_q == S_GRANT)
                || (state_q == S_XFER);

  assign bus.HRQ        = (state_q == S_REQ) || bus_act;
  assign bus.DACK       = bus_act ? (NUM_CH'(1) << grant_q)
                                  : '0;
  assign bus.GRANT_CH   = grant_q;
  assign bus.XFER_START = (state_q == S_GRANT);
  assign bus.XFER_ABORT = abort_q;
  assign TC_STATUS      = tcs_q;

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench for dma_channel_scheduler.
// Emulates CPU hold handshake and transfer timing block.
module tb_dma_channel_scheduler;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ, MASK, CLR_TC, TC_STATUS;
  logic       ROTATE;
  logic [7:0] MODE;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0] m_tcs;
  int         m_ptr;

  dma_channel_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

  dma_channel_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .DREQ      (DREQ),
    .MASK      (MASK),
    .ROTATE    (ROTATE),
    .MODE      (MODE),
    .CLR_TC    (CLR_TC),
    .TC_STATUS (TC_STATUS),
    .bus       (bus)
  );

  always #5 CLK = ~CLK;

  // Reference: priority rule from the channel ordering.
  function automatic int m_winner(logic [3:0] e, logic rot, int ptr);
    int c;
    for (int k = 0; k < 4; k++) begin
      c = rot ? (ptr + 1 + k) % 4 : k;
      if (((e >> c) & 4'd1) != 4'd0) return c;
    end
    return -1;
  endfunction

  // Reference: transfers in one bus tenure and whether it ends in TC.
  function automatic int m_count(int md, int tc_on, int eop_on,
                                 int drop, output bit term);
    int t, stop;
    if (tc_on == 0) t = eop_on;
    else if (eop_on == 0) t = tc_on;
    else t = (tc_on < eop_on) ? tc_on : eop_on;
    if (md == 2) stop = 0;
    else if (md == 0) stop = drop;
    else stop = 1;
    if (t != 0 && (stop == 0 || t <= stop)) begin
      term = 1'b1;
      return t;
    end
    term = 1'b0;
    return stop;
  endfunction

  function automatic int mode_of(int c);
    logic [7:0] sh;
    sh = MODE >> (2 * c);
    return int'(sh[1:0]);
  endfunction

  function automatic int oh_idx(logic [3:0] v);
    int r, cnt;
    r = -1;
    cnt = 0;
    for (int i = 0; i < 4; i++)
      if (v[i]) begin
        r = i;
        cnt++;
      end
    return (cnt == 1) ? r : -1;
  endfunction

  // One bus tenure: HLDA follows HRQ, DONE after 1..3 cycles.
  task automatic run_service(input int tc_on, input int eop_on,
                             input int drop, input bit clr_tc,
                             output int n, output int ch,
                             output bit tmo, output bit gbad);
    int budget, wcnt;
    bit waiting, eop_done;
    n = 0; ch = -1; tmo = 0; gbad = 0;
    budget = 0; wcnt = 0; waiting = 0; eop_done = 0;
    forever begin
      @(negedge CLK);
      bus.XFER_DONE = 1'b0;
      bus.TC = 1'b0;
      bus.EOP_N = 1'b1;
      CLR_TC = 4'b0;
      if (bus.HLDA && !bus.HRQ) begin
        bus.HLDA = 1'b0;
        DREQ = 4'b0;
        break;
      end
      budget++;
      if (budget > 300) begin
        tmo = 1'b1;
        bus.HLDA = 1'b0;
        DREQ = 4'b0;
        break;
      end
      bus.HLDA = bus.HRQ;
      if (bus.XFER_START) begin
        n++;
        ch = oh_idx(bus.DACK);
        if (ch < 0 || int'(bus.GRANT_CH) != ch) gbad = 1'b1;
        wcnt = (n == eop_on) ? int'($urandom_range(2, 3))
                             : int'($urandom_range(1, 3));
        waiting = 1'b1;
        eop_done = 1'b0;
      end else if (waiting) begin
        wcnt--;
        if (wcnt == 0) begin
          waiting = 1'b0;
          bus.XFER_DONE = 1'b1;
          bus.TC = (n == tc_on);
          if (bus.TC && clr_tc && ch >= 0) CLR_TC = 4'b1 << ch;
          if (n == drop && ch >= 0) DREQ = DREQ & ~(4'b1 << ch);
        end else if (n == eop_on && !eop_done) begin
          bus.EOP_N = 1'b0;
          eop_done = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    n_checks++;
    if ({bus.HRQ, bus.DACK, bus.GRANT_CH, bus.XFER_START,
         bus.XFER_ABORT, TC_STATUS} !== 13'd0)
      $display("FAIL reset_held: outs=%b want 0", {bus.HRQ, bus.DACK,
               bus.GRANT_CH, bus.XFER_START, bus.XFER_ABORT, TC_STATUS});
    else n_pass++;
    RESET_N = 1'b1;
    @(negedge CLK);
    n_checks++;
    if ({bus.HRQ, bus.DACK, bus.GRANT_CH, bus.XFER_START,
         bus.XFER_ABORT, TC_STATUS} !== 13'd0)
      $display("FAIL reset_rel: outs=%b want 0", {bus.HRQ, bus.DACK,
               bus.GRANT_CH, bus.XFER_START, bus.XFER_ABORT, TC_STATUS});
    else n_pass++;
  endtask

  task automatic test_fixed();
    int n, ch, w;
    bit tmo, gbad;
    MODE = 8'h55; ROTATE = 1'b0; MASK = 4'h0;
    for (int s = 0; s < 3; s++) begin
      DREQ = 4'hF;
      w = m_winner(DREQ & ~MASK & ~m_tcs, ROTATE, m_ptr);
      run_service(0, 0, 0, 1'b0, n, ch, tmo, gbad);
      n_checks++;
      if ({8'(ch), 8'(n), tmo, gbad} !== {8'(w), 8'd1, 2'b00})
        $display("FAIL fixed[%0d]: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=%0d n=1",
                 s, ch, n, tmo, gbad, w);
      else n_pass++;
    end
  endtask

  task automatic test_rotating();
    int n, ch, w;
    bit tmo, gbad;
    MODE = 8'h55; ROTATE = 1'b1; MASK = 4'h0;
    for (int s = 0; s < 5; s++) begin
      DREQ = 4'hF;
      w = m_winner(DREQ & ~MASK & ~m_tcs, ROTATE, m_ptr);
      run_service(0, 0, 0, 1'b0, n, ch, tmo, gbad);
      m_ptr = w;
      n_checks++;
      if ({8'(ch), 8'(n), tmo, gbad} !== {8'(w), 8'd1, 2'b00})
        $display("FAIL rotate[%0d]: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=%0d n=1",
                 s, ch, n, tmo, gbad, w);
      else n_pass++;
    end
  endtask

  task automatic test_block();
    int n, ch, en;
    bit tmo, gbad, term, seen;
    MODE = 8'b0101_1001; ROTATE = 1'b0; MASK = 4'h0;
    DREQ = 4'b0010;
    en = m_count(2, 3, 0, 0, term);
    run_service(3, 0, 0, 1'b0, n, ch, tmo, gbad);
    if (term) m_tcs = m_tcs | 4'b0010;
    n_checks++;
    if ({8'(ch), 8'(n), tmo, gbad} !== {8'd1, 8'(en), 2'b00})
      $display("FAIL block: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=1 n=%0d",
               ch, n, tmo, gbad, en);
    else n_pass++;
    n_checks++;
    if (TC_STATUS !== m_tcs)
      $display("FAIL block_tc: TC_STATUS=%b want %b", TC_STATUS, m_tcs);
    else n_pass++;
    DREQ = 4'b0010;
    seen = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      if (bus.HRQ) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL block_excl: HRQ seen=%0d want 0", seen);
    else n_pass++;
    CLR_TC = 4'b0010;
    @(negedge CLK);
    CLR_TC = 4'b0;
    m_tcs = m_tcs & ~4'b0010;
    n_checks++;
    if (TC_STATUS !== m_tcs)
      $display("FAIL block_clr: TC_STATUS=%b want %b", TC_STATUS, m_tcs);
    else n_pass++;
    seen = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      if (bus.HRQ) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL block_rereq: HRQ seen=%0d want 1", seen);
    else n_pass++;
    MODE = 8'h55;
    run_service(0, 0, 0, 1'b0, n, ch, tmo, gbad);
    n_checks++;
    if ({8'(ch), 8'(n), tmo, gbad} !== {8'd1, 8'd1, 2'b00})
      $display("FAIL block_after: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=1 n=1",
               ch, n, tmo, gbad);
    else n_pass++;
  endtask

  task automatic test_demand();
    int n, ch, en;
    bit tmo, gbad, term;
    MODE = 8'b0100_0101; ROTATE = 1'b0; MASK = 4'h0;
    DREQ = 4'b0100;
    en = m_count(0, 0, 0, 2, term);
    run_service(0, 0, 2, 1'b0, n, ch, tmo, gbad);
    n_checks++;
    if ({8'(ch), 8'(n), tmo, gbad} !== {8'd2, 8'(en), 2'b00})
      $display("FAIL demand: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=2 n=%0d",
               ch, n, tmo, gbad, en);
    else n_pass++;
    n_checks++;
    if (TC_STATUS !== m_tcs)
      $display("FAIL demand_tc: TC_STATUS=%b want %b", TC_STATUS, m_tcs);
    else n_pass++;
  endtask

  task automatic test_eop();
    int n, ch, en;
    bit tmo, gbad, term;
    MODE = 8'b1001_0101; ROTATE = 1'b0; MASK = 4'h0;
    DREQ = 4'b1000;
    en = m_count(2, 0, 1, 0, term);
    run_service(0, 1, 0, 1'b0, n, ch, tmo, gbad);
    if (term) m_tcs = m_tcs | 4'b1000;
    n_checks++;
    if ({8'(ch), 8'(n), tmo, gbad} !== {8'd3, 8'(en), 2'b00})
      $display("FAIL eop: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=3 n=%0d",
               ch, n, tmo, gbad, en);
    else n_pass++;
    n_checks++;
    if (TC_STATUS !== m_tcs)
      $display("FAIL eop_tc: TC_STATUS=%b want %b", TC_STATUS, m_tcs);
    else n_pass++;
    CLR_TC = 4'b1000;
    @(negedge CLK);
    CLR_TC = 4'b0;
    m_tcs = m_tcs & ~4'b1000;
  endtask

  task automatic test_abort();
    int n, ch, budget;
    bit tmo, gbad, seen;
    MODE = 8'h55; ROTATE = 1'b0; MASK = 4'h0;
    DREQ = 4'b0001;
    seen = 1'b0;
    budget = 0;
    while (budget < 20 && !seen) begin
      @(negedge CLK);
      budget++;
      bus.HLDA = bus.HRQ;
      if (bus.XFER_START) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b1) $display("FAIL abort_start: start seen=%0d want 1", seen);
    else n_pass++;
    @(negedge CLK);
    bus.HLDA = 1'b0;
    @(negedge CLK);
    n_checks++;
    if ({bus.XFER_ABORT, bus.HRQ, bus.DACK} !== 6'b10_0000)
      $display("FAIL abort_pulse: abort/hrq/dack=%b want 100000",
               {bus.XFER_ABORT, bus.HRQ, bus.DACK});
    else n_pass++;
    n_checks++;
    if (TC_STATUS !== m_tcs)
      $display("FAIL abort_tc: TC_STATUS=%b want %b", TC_STATUS, m_tcs);
    else n_pass++;
    @(negedge CLK);
    n_checks++;
    if ({bus.XFER_ABORT, bus.HRQ} !== 2'b01)
      $display("FAIL abort_rereq: abort/hrq=%b want 01",
               {bus.XFER_ABORT, bus.HRQ});
    else n_pass++;
    run_service(0, 0, 0, 1'b0, n, ch, tmo, gbad);
    n_checks++;
    if ({8'(ch), 8'(n), tmo, gbad} !== {8'd0, 8'd1, 2'b00})
      $display("FAIL abort_after: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=0 n=1",
               ch, n, tmo, gbad);
    else n_pass++;
  endtask

  task automatic test_mask();
    bit seen;
    MASK = 4'b1110;
    DREQ = 4'b1110;
    seen = 1'b0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.HRQ) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) $display("FAIL mask: HRQ seen=%0d want 0", seen);
    else n_pass++;
    DREQ = 4'b0;
    MASK = 4'b0;
  endtask

  task automatic test_set_clr();
    int n, ch;
    bit tmo, gbad;
    MODE = 8'h55; ROTATE = 1'b0; MASK = 4'h0;
    DREQ = 4'b0001;
    run_service(1, 0, 0, 1'b1, n, ch, tmo, gbad);
    m_tcs = m_tcs | 4'b0001;
    n_checks++;
    if ({8'(ch), 8'(n), tmo, gbad} !== {8'd0, 8'd1, 2'b00})
      $display("FAIL setclr_svc: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=0 n=1",
               ch, n, tmo, gbad);
    else n_pass++;
    n_checks++;
    if (TC_STATUS !== m_tcs)
      $display("FAIL setclr_win: TC_STATUS=%b want %b", TC_STATUS, m_tcs);
    else n_pass++;
    CLR_TC = 4'b0001;
    @(negedge CLK);
    CLR_TC = 4'b0;
    m_tcs = m_tcs & ~4'b0001;
    n_checks++;
    if (TC_STATUS !== m_tcs)
      $display("FAIL setclr_clr: TC_STATUS=%b want %b", TC_STATUS, m_tcs);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int n, ch, w, budget;
    bit tmo, gbad, seen;
    MODE = 8'h55; ROTATE = 1'b1; MASK = 4'h0;
    DREQ = 4'b0001;
    run_service(0, 0, 0, 1'b0, n, ch, tmo, gbad);
    m_ptr = 0;
    MODE = 8'b1001_0101;
    DREQ = 4'b1000;
    seen = 1'b0;
    budget = 0;
    while (budget < 20 && !seen) begin
      @(negedge CLK);
      budget++;
      bus.HLDA = bus.HRQ;
      if (bus.XFER_START) seen = 1'b1;
    end
    @(negedge CLK);
    #2 RESET_N = 1'b0;
    #1;
    n_checks++;
    if ({seen, bus.HRQ, bus.DACK, bus.GRANT_CH, bus.XFER_START,
         bus.XFER_ABORT, TC_STATUS} !== 14'b1_0000_0000_0000_0)
      $display("FAIL reset_mid: seen/outs=%b want 1 then zeros", {seen,
               bus.HRQ, bus.DACK, bus.GRANT_CH, bus.XFER_START,
               bus.XFER_ABORT, TC_STATUS});
    else n_pass++;
    @(negedge CLK);
    RESET_N = 1'b1;
    bus.HLDA = 1'b0;
    m_tcs = 4'b0;
    m_ptr = 3;
    MODE = 8'h55;
    DREQ = 4'hF;
    w = m_winner(DREQ & ~MASK & ~m_tcs, ROTATE, m_ptr);
    run_service(0, 0, 0, 1'b0, n, ch, tmo, gbad);
    m_ptr = w;
    n_checks++;
    if ({8'(ch), 8'(n), tmo, gbad} !== {8'(w), 8'd1, 2'b00})
      $display("FAIL reset_prio: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=%0d n=1",
               ch, n, tmo, gbad, w);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [3:0] clr, e;
      int w, md, tc_on, eop_on, drop, n, ch, en;
      bit tmo, gbad, term, seen;
      clr = 4'($urandom_range(0, 15));
      CLR_TC = clr;
      @(negedge CLK);
      CLR_TC = 4'b0;
      m_tcs = m_tcs & ~clr;
      DREQ = 4'($urandom);
      MASK = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      ROTATE = 1'($urandom_range(0, 1));
      MODE = 8'($urandom);
      e = DREQ & ~MASK & ~m_tcs;
      if (e == 4'b0) begin
        seen = 1'b0;
        repeat (6) begin
          @(negedge CLK);
          if (bus.HRQ) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0)
          $display("FAIL rnd_idle[%0d]: HRQ seen=%0d want 0", it, seen);
        else n_pass++;
        DREQ = 4'b0;
      end else begin
        w = m_winner(e, ROTATE, m_ptr);
        md = mode_of(w);
        tc_on = int'($urandom_range(0, 3));
        eop_on = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        drop = (md == 0) ? int'($urandom_range(0, 3)) : 0;
        if (md == 2 && tc_on == 0 && eop_on == 0) tc_on = 2;
        if (md == 0 && tc_on == 0 && eop_on == 0 && drop == 0) drop = 1;
        en = m_count(md, tc_on, eop_on, drop, term);
        run_service(tc_on, eop_on, drop, 1'($urandom_range(0, 1)),
                    n, ch, tmo, gbad);
        if (term) m_tcs = m_tcs | (4'b1 << w);
        if (ROTATE) m_ptr = w;
        n_checks++;
        if ({8'(ch), 8'(n), tmo, gbad} !== {8'(w), 8'(en), 2'b00})
          $display("FAIL rnd_svc[%0d]: ch=%0d n=%0d tmo=%0d gbad=%0d want ch=%0d n=%0d",
                   it, ch, n, tmo, gbad, w, en);
        else n_pass++;
        n_checks++;
        if (TC_STATUS !== m_tcs)
          $display("FAIL rnd_tc[%0d]: TC_STATUS=%b want %b",
                   it, TC_STATUS, m_tcs);
        else n_pass++;
      end
    end
  endtask

  initial begin
    RESET_N = 1'b0;
    DREQ = 4'b0; MASK = 4'b0; CLR_TC = 4'b0;
    ROTATE = 1'b0; MODE = 8'h55;
    bus.HLDA = 1'b0;
    bus.XFER_DONE = 1'b0;
    bus.TC = 1'b0;
    bus.EOP_N = 1'b1;
    m_tcs = 4'b0;
    m_ptr = 3;
    test_reset();
    test_fixed();
    test_rotating();
    test_block();
    test_demand();
    test_eop();
    test_abort();
    test_mask();
    test_set_clr();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
